// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - shares the dram read/write ports between display scanout (D) and raster writer (R)
// One operation outstanding at a time; D has priority, bounded by a starvation guard for R.
module dram_port_arbiter #(
  parameter int ADDR_BITS    = 27,
  parameter int DATA_BITS    = 4096,
  parameter int STARVE_LIMIT = 4,
  parameter int RD_TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 calib_done,
  input  logic                 d_req,
  input  logic [ADDR_BITS-1:0] d_addr,
  output logic                 d_gnt,
  output logic                 d_valid,
  output logic [DATA_BITS-1:0] d_data,
  input  logic                 r_req,
  input  logic [ADDR_BITS-1:0] r_addr,
  input  logic [DATA_BITS-1:0] r_data,
  output logic                 r_gnt,
  output logic                 r_done,
  input  logic                 mem_rd_ready,
  output logic                 mem_rd_req,
  output logic [ADDR_BITS-1:0] mem_rd_addr,
  input  logic                 mem_rd_resp,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  input  logic                 mem_wr_ready,
  output logic                 mem_wr_req,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic [DATA_BITS-1:0] mem_wr_data,
  output logic                 busy,
  output logic                 rd_timeout
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_WR_WAIT  = 3'd4;

  logic [2:0]           r_state;
  logic [SW-1:0]        r_starve_cnt;
  logic [TW-1:0]        r_timer;
  logic                 r_wr_armed;
  logic                 r_d_valid;
  logic                 r_rd_timeout;
  logic [ADDR_BITS-1:0] r_mem_rd_addr;
  logic [ADDR_BITS-1:0] r_mem_wr_addr;
  logic [DATA_BITS-1:0] r_mem_wr_data;
  logic [DATA_BITS-1:0] r_d_data;

  logic w_idle;
  logic w_arb_en;
  logic w_d_elig;
  logic w_r_elig;
  logic w_r_first;
  logic w_d_gnt;
  logic w_r_gnt;

  // Grants are decided combinationally in IDLE; rst_n gating keeps them quiet while reset is held.
  assign w_idle    = (r_state == S_IDLE);
  assign w_arb_en  = rst_n && calib_done && w_idle;
  assign w_d_elig  = d_req && mem_rd_ready;
  assign w_r_elig  = r_req && mem_wr_ready;
  assign w_r_first = (r_starve_cnt == SW'(STARVE_LIMIT)) && w_r_elig;
  assign w_d_gnt   = w_arb_en && w_d_elig && !w_r_first;
  assign w_r_gnt   = w_arb_en && w_r_elig && (w_r_first || !w_d_elig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_wr_armed    <= 1'b0;
      r_d_valid     <= 1'b0;
      r_rd_timeout  <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_d_data      <= '0;
    end else begin
      r_d_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_gnt) begin
            r_mem_rd_addr <= d_addr;
            r_state       <= S_RD_ISSUE;
          end else if (w_r_gnt) begin
            r_mem_wr_addr <= r_addr;
            r_mem_wr_data <= r_data;
            r_state       <= S_WR_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          r_timer <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mem_rd_resp) begin
            r_d_data  <= mem_rd_data;
            r_d_valid <= 1'b1;
            r_state   <= S_IDLE;
          end else if (r_timer == TW'(RD_TIMEOUT - 1)) begin
            r_rd_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WR_ISSUE: begin
          r_wr_armed <= 1'b0;
          r_state    <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          // write_ready still reflects the previous op on the first cycle, so it is not trusted yet
          r_wr_armed <= 1'b1;
          if (r_wr_armed && mem_wr_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_r_gnt || (w_idle && !r_req)) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign d_gnt       = w_d_gnt;
  assign r_gnt       = w_r_gnt;
  assign d_valid     = r_d_valid;
  assign d_data      = r_d_data;
  assign r_done      = (r_state == S_WR_WAIT) && r_wr_armed && mem_wr_ready;
  assign mem_rd_req  = (r_state == S_RD_ISSUE);
  assign mem_rd_addr = r_mem_rd_addr;
  assign mem_wr_req  = (r_state == S_WR_ISSUE);
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign busy        = !w_idle;
  assign rd_timeout  = r_rd_timeout;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;
  localparam int AW = 27;
  localparam int DW = 4096;
  localparam int SL = 4;
  localparam int TO = 1023;
  localparam int OP_NONE = 0;
  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          calib_done = 1'b0;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_gnt, d_valid;
  logic [DW-1:0] d_data;
  logic          r_req = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] r_data = '0;
  logic          r_gnt, r_done;
  logic          mem_rd_ready = 1'b0;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_resp = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_wr_ready = 1'b0;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          busy, rd_timeout;

  dram_port_arbiter #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .STARVE_LIMIT(SL), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_valid(d_valid), .d_data(d_data),
    .r_req(r_req), .r_addr(r_addr), .r_data(r_data), .r_gnt(r_gnt), .r_done(r_done),
    .mem_rd_ready(mem_rd_ready), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_resp(mem_rd_resp), .mem_rd_data(mem_rd_data),
    .mem_wr_ready(mem_wr_ready), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state (transaction level)
  int            op = OP_NONE;
  int            age = 0;
  int            starve = 0;
  logic [AW-1:0] exp_rd_addr = '0;
  logic [AW-1:0] exp_wr_addr = '0;
  logic [DW-1:0] exp_wr_data = '0;
  logic          rsp_prev = 1'b0;
  logic          rsp_pend = 1'b0;
  int            rsp_left = 0;
  logic [AW-1:0] rsp_addr = '0;
  logic [DW-1:0] rsp_data = '0;
  logic          gnt_d_seen = 1'b0;
  logic          gnt_r_seen = 1'b0;
  logic          stop = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits) at %0t", tag, got[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_blk();
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = 32'(a) ^ (32'(i) * 32'h9E37_79B1);
    return b;
  endfunction

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic model_reset();
    op = OP_NONE; age = 0; starve = 0; rsp_prev = 1'b0; rsp_pend = 1'b0;
    gnt_d_seen = 1'b0; gnt_r_seen = 1'b0;
  endtask

  task automatic monitor();
    logic idle, dv_exp, de, re, e_d, e_r, e_done;
    if (op != OP_NONE) age++;
    dv_exp = rsp_prev;
    check("d_valid", DW'(d_valid), DW'(dv_exp));
    if (dv_exp) begin
      check("d_data", d_data, rsp_data);
      op = OP_NONE;
    end
    idle = (op == OP_NONE);
    check("busy", DW'(busy), DW'(!idle));
    de  = d_req && mem_rd_ready;
    re  = r_req && mem_wr_ready;
    e_r = idle && calib_done && re && (starve == SL || !de);
    e_d = idle && calib_done && de && !e_r;
    check("gnt", DW'({d_gnt, r_gnt}), DW'({e_d, e_r}));
    if (idle) begin
      if (e_r || !r_req) starve = 0;
      else if (e_d && starve < SL) starve++;
    end
    check("mem_rd_req", DW'(mem_rd_req), DW'(op == OP_RD && age == 1));
    if (op == OP_RD && age == 1) begin
      check("mem_rd_addr", DW'(mem_rd_addr), DW'(exp_rd_addr));
      rsp_pend = 1'b1;
      rsp_left = $urandom_range(6, 1);
      rsp_addr = exp_rd_addr;
    end
    check("mem_wr_req", DW'(mem_wr_req), DW'(op == OP_WR && age == 1));
    if (op == OP_WR && age == 1) begin
      check("mem_wr_addr", DW'(mem_wr_addr), DW'(exp_wr_addr));
      check("mem_wr_data", mem_wr_data, exp_wr_data);
    end
    e_done = (op == OP_WR) && (age >= 3) && mem_wr_ready;
    check("r_done", DW'(r_done), DW'(e_done));
    if (e_done) op = OP_NONE;
    if (e_d) begin op = OP_RD; age = 0; exp_rd_addr = d_addr; end
    if (e_r) begin op = OP_WR; age = 0; exp_wr_addr = r_addr; exp_wr_data = r_data; end
    rsp_prev   = mem_rd_resp;
    gnt_d_seen = d_gnt;
    gnt_r_seen = r_gnt;
  endtask

  task automatic auto_drive(input int mode);
    mem_rd_resp = 1'b0;
    mem_rd_data = {(DW/32){$urandom}};
    if (rsp_pend) begin
      if (rsp_left == 0) begin
        rsp_data    = mem_fn(rsp_addr);
        mem_rd_resp = 1'b1;
        mem_rd_data = rsp_data;
        rsp_pend    = 1'b0;
      end else begin
        rsp_left--;
      end
    end
    if (gnt_r_seen) r_data = rnd_blk();
    if (mode == 1) begin
      mem_rd_ready = 1'b1;
      mem_wr_ready = 1'b1;
      if (gnt_d_seen) d_addr = AW'($urandom);
      if (gnt_r_seen) r_addr = AW'($urandom);
      d_req = !stop;
      r_req = !stop;
    end else begin
      mem_rd_ready = ($urandom_range(3) != 0);
      mem_wr_ready = ($urandom_range(1) != 0);
      if (stop) calib_done = 1'b1;
      else if ($urandom_range(19) == 0) calib_done = !calib_done;
      if (gnt_d_seen || stop || (d_req && $urandom_range(15) == 0)) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin d_req = 1'b1; d_addr = AW'($urandom); end
      if (gnt_r_seen || stop || (r_req && $urandom_range(15) == 0)) r_req = 1'b0;
      else if (!r_req && $urandom_range(2) == 0) begin
        r_req = 1'b1; r_addr = AW'($urandom); r_data = rnd_blk();
      end
    end
  endtask

  task automatic run_auto(input int mode, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drv();
      auto_drive(mode);
      smp();
      monitor();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic          bad;
    logic          dv;
    int            n, ng, nd;
    byte           got_c, exp_c;

    // reset state, with requests active to prove grants are held off
    calib_done = 1'b1; d_req = 1'b1; r_req = 1'b1; mem_rd_ready = 1'b1; mem_wr_ready = 1'b1;
    smp();
    check("rst_gnt", DW'({d_gnt, r_gnt}), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_pulses", DW'({d_valid, r_done, mem_rd_req, mem_wr_req, rd_timeout}), DW'(0));
    check("rst_regs", DW'({mem_rd_addr, mem_wr_addr}), DW'(0));
    check("rst_data", mem_wr_data | d_data, '0);
    calib_done = 1'b0;
    drv();
    rst_n = 1'b1;

    // calibration not done: nothing may happen
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drv();
      smp();
      bad |= d_gnt | r_gnt | mem_rd_req | mem_wr_req | busy;
    end
    check("calib_gate", DW'(bad), DW'(0));

    // single read with 5-cycle response
    drv();
    calib_done = 1'b1; r_req = 1'b0; d_req = 1'b1; d_addr = AW'(32'h400);
    smp();
    check("rd_gnt", DW'({d_gnt, r_gnt}), DW'(2'b10));
    drv();
    d_req = 1'b0;
    smp();
    check("rd_issue", DW'(mem_rd_req), DW'(1));
    check("rd_addr", DW'(mem_rd_addr), DW'(32'h400));
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv();
      smp();
      bad |= d_valid | mem_rd_req;
    end
    check("rd_wait_quiet", DW'(bad), DW'(0));
    v = rnd_blk();
    v[DW-1 -: 12] = 12'hABC;
    v[3:0] = 4'h1;
    drv();
    mem_rd_resp = 1'b1; mem_rd_data = v;
    smp();
    check("rd_valid_early", DW'(d_valid), DW'(0));
    drv();
    mem_rd_resp = 1'b0; mem_rd_data = rnd_blk();
    smp();
    check("rd_valid", DW'(d_valid), DW'(1));
    check("rd_data", d_data, v);
    check("rd_idle", DW'(busy), DW'(0));
    drv();
    smp();
    check("rd_valid_pulse", DW'(d_valid), DW'(0));
    check("rd_data_hold", d_data, v);

    // both requesters saturated: D x SL then R, repeating
    model_reset();
    stop = 1'b0;
    d_addr = AW'($urandom); r_addr = AW'($urandom); r_data = rnd_blk();
    ng = 0; nd = 0;
    for (int i = 0; i < 600 && ng < 15; i++) begin
      drv();
      auto_drive(1);
      smp();
      if (d_gnt || r_gnt) begin
        got_c = d_gnt ? "D" : "R";
        exp_c = ((ng % (SL + 1)) == SL) ? "R" : "D";
        check("starve_pattern", DW'(got_c), DW'(exp_c));
        ng++;
      end
      if (r_done) nd++;
      monitor();
    end
    check("pattern_count", DW'(ng), DW'(15));
    stop = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drv();
      auto_drive(1);
      smp();
      if (r_done) nd++;
      monitor();
    end
    check("pattern_r_done", DW'(nd), DW'(15 / (SL + 1)));
    stop = 1'b0;

    // write with ready dropping then rising; r_data changes after grant
    drv();
    d_req = 1'b0; r_req = 1'b1; r_addr = AW'(32'h1200); v = rnd_blk(); r_data = v;
    mem_wr_ready = 1'b1; mem_rd_resp = 1'b0;
    smp();
    check("wr_gnt", DW'({d_gnt, r_gnt}), DW'(2'b01));
    drv();
    r_req = 1'b0; r_data = ~v;
    smp();
    check("wr_issue", DW'(mem_wr_req), DW'(1));
    check("wr_addr", DW'(mem_wr_addr), DW'(32'h1200));
    check("wr_data", mem_wr_data, v);
    drv();
    mem_wr_ready = 1'b0;
    smp();
    bad = r_done;
    drv(); smp(); bad |= r_done;
    drv(); smp(); bad |= r_done;
    check("wr_no_done_early", DW'(bad), DW'(0));
    drv();
    mem_wr_ready = 1'b1;
    smp();
    check("wr_done", DW'(r_done), DW'(1));
    check("wr_data_hold", mem_wr_data, v);
    drv();
    smp();
    check("wr_idle", DW'({busy, r_done}), DW'(0));

    // read timeout
    drv();
    d_req = 1'b1; d_addr = AW'($urandom); mem_rd_ready = 1'b1;
    smp();
    check("to_gnt", DW'(d_gnt), DW'(1));
    drv();
    d_req = 1'b0;
    smp();
    check("to_issue", DW'(mem_rd_req), DW'(1));
    n = 0; dv = 1'b0;
    while (busy && n < TO + 100) begin
      drv();
      smp();
      n++;
      dv |= d_valid;
    end
    check("to_latency", DW'(n >= TO && n <= TO + 2), DW'(1));
    check("to_flag", DW'(rd_timeout), DW'(1));
    drv();
    mem_rd_resp = 1'b1; mem_rd_data = rnd_blk();
    smp();
    dv |= d_valid;
    drv();
    mem_rd_resp = 1'b0;
    smp();
    dv |= d_valid;
    check("to_no_valid", DW'(dv), DW'(0));
    drv();
    r_req = 1'b1; r_addr = AW'($urandom); r_data = rnd_blk(); mem_wr_ready = 1'b1;
    smp();
    check("to_next_gnt", DW'(r_gnt), DW'(1));
    drv();
    r_req = 1'b0;
    smp();
    bad = 1'b0;
    for (int i = 0; i < 10 && !bad; i++) begin
      drv();
      smp();
      bad = r_done;
    end
    check("to_next_done", DW'(bad), DW'(1));
    check("to_sticky", DW'(rd_timeout), DW'(1));
    drv();
    smp();

    // asynchronous reset while waiting for read data
    drv();
    d_req = 1'b1; d_addr = AW'($urandom);
    smp();
    check("ar_gnt", DW'(d_gnt), DW'(1));
    drv(); smp();
    drv(); smp();
    check("ar_busy", DW'(busy), DW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_outs", DW'({busy, d_gnt, r_gnt, mem_rd_req, mem_wr_req, d_valid, r_done, rd_timeout}), DW'(0));
    check("ar_addr", DW'(mem_rd_addr), DW'(0));
    drv();
    rst_n = 1'b1;
    d_addr = AW'($urandom);
    smp();
    check("ar_regnt", DW'(d_gnt), DW'(1));
    drv();
    d_req = 1'b0;
    smp();
    check("ar_issue_addr", DW'({mem_rd_req, mem_rd_addr}), DW'({1'b1, d_addr}));
    v = rnd_blk();
    drv();
    mem_rd_resp = 1'b1; mem_rd_data = v;
    smp();
    drv();
    mem_rd_resp = 1'b0;
    smp();
    check("ar_valid", DW'(d_valid), DW'(1));
    check("ar_data", d_data, v);

    // randomized traffic against the reference model
    model_reset();
    calib_done = 1'b1;
    run_auto(2, 3000);
    stop = 1'b1;
    run_auto(2, 60);
    check("drain_idle", DW'(busy), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
